mc_ctrl: RTL and testbench

//  Multi-cycle main controller for the P-series MIPS datapath. Decodes opcode/funct
//  and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, driving PC, IR,
//  GRF, EXT (ext_op), ALU and DM controls. Data-memory accesses use a req/ready

---
 rtl/mc_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: sequences FETCH/DECODE/EXEC/MEM/WB and drives
// PC, IR, GRF, EXT, ALU and DM controls for the MIPS datapath.
module mc_ctrl #(
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_wr,
  output logic [1:0] pc_src,
  output logic       ir_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] wd_sel,
  output logic       ext_op,
  output logic       alu_src_b,
  output logic [2:0] alu_op,
  output logic       mem_req,
  output logic       mem_we,
  output logic [2:0] state,
  output logic       instr_done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LW, I_SW, I_BEQ, I_LUI, I_JAL, I_ILL
  } instr_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [5:0] op_q, fn_q;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  instr_t     cls;

  // The all-zero word (funct 000000) is accepted as addu so nop completes.
  function automatic instr_t decode(input logic [5:0] op, input logic [5:0] fn);
    instr_t c;
    c = I_ILL;
    case (op)
      6'b000000: begin
        case (fn)
          6'b100001, 6'b000000: c = I_ADDU;
          6'b100011:            c = I_SUBU;
          6'b001000:            c = I_JR;
          default:              c = I_ILL;
        endcase
      end
      6'b001101: c = I_ORI;
      6'b100011: c = I_LW;
      6'b101011: c = I_SW;
      6'b000100: c = I_BEQ;
      6'b001111: c = I_LUI;
      6'b000011: c = I_JAL;
      default:   c = I_ILL;
    endcase
    return c;
  endfunction

  // IR holds the new word during DECODE; later states use the latched copy.
  assign cls = (state_q == S_DECODE) ? decode(opcode, funct) : decode(op_q, fn_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      op_q    <= 6'd0;
      fn_q    <= 6'd0;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (state_q == S_DECODE) begin
        op_q <= opcode;
        fn_q <= funct;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    pc_wr      = 1'b0;
    pc_src     = 2'd0;
    ir_wr      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'd0;
    wd_sel     = 2'd0;
    ext_op     = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 3'd0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        ext_op = (cls == I_ORI) || (cls == I_LUI);
        case (cls)
          I_ILL: begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
          I_JAL: begin
            pc_wr      = 1'b1;
            pc_src     = 2'd2;
            reg_wr     = 1'b1;
            reg_dst    = 2'd2;
            wd_sel     = 2'd2;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          I_JR: begin
            pc_wr      = 1'b1;
            pc_src     = 2'd3;
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        ext_op    = (cls == I_ORI) || (cls == I_LUI);
        alu_src_b = (cls == I_ORI) || (cls == I_LUI) || (cls == I_LW) || (cls == I_SW);
        case (cls)
          I_SUBU, I_BEQ: alu_op = 3'd1;
          I_ORI:         alu_op = 3'd2;
          I_LUI:         alu_op = 3'd3;
          default:       alu_op = 3'd0;
        endcase
        if (cls == I_BEQ) begin
          pc_wr      = zero;
          pc_src     = 2'd1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (cls == I_LW || cls == I_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls == I_SW);
        if (mem_ready) begin
          cnt_d = 8'd0;
          if (cls == I_SW) begin
            instr_done = 1'b1;
            state_d    = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == WAIT_LAST) begin
          cnt_d   = 8'd0;
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        ext_op     = (cls == I_ORI) || (cls == I_LUI);
        reg_dst    = (cls == I_ADDU || cls == I_SUBU) ? 2'd1 : 2'd0;
        wd_sel     = (cls == I_LW) ? 2'd1 : 2'd0;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: begin
        err_d   = 1'b1;
        state_d = S_HALT;
      end
    endcase
    // Enables must fall the moment reset is asserted, not at the next edge.
    if (!reset_n) begin
      pc_wr      = 1'b0;
      pc_src     = 2'd0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      reg_dst    = 2'd0;
      wd_sel     = 2'd0;
      ext_op     = 1'b0;
      alu_src_b  = 1'b0;
      alu_op     = 3'd0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = state_q;
  assign err   = err_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction cycle schedules derived from the ISA
// rules are compared against all DUT outputs every cycle.
module tb_mc_ctrl;
  localparam int W    = 21;
  localparam int MAXW = 8;
  localparam int C_ADDU = 0, C_SUBU = 1, C_NOP = 2, C_JR = 3, C_ORI = 4, C_LW = 5;
  localparam int C_SW = 6, C_BEQ = 7, C_LUI = 8, C_JAL = 9, C_ILL = 10;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [5:0] opcode = 6'd0, funct = 6'd0;
  logic zero = 1'b0, mem_ready = 1'b0;
  logic pc_wr, ir_wr, reg_wr, ext_op, alu_src_b, mem_req, mem_we, instr_done, err;
  logic [1:0] pc_src, reg_dst, wd_sel;
  logic [2:0] alu_op, state;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  logic [5:0] cur_op, cur_fn;
  logic [W-1:0] act;

  mc_ctrl #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_wr(pc_wr), .pc_src(pc_src), .ir_wr(ir_wr),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .wd_sel(wd_sel), .ext_op(ext_op),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .mem_req(mem_req), .mem_we(mem_we),
    .state(state), .instr_done(instr_done), .err(err)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign act = {pc_wr, pc_src, ir_wr, reg_wr, reg_dst, wd_sel, ext_op, alu_src_b,
                alu_op, mem_req, mem_we, state, instr_done, err};

  function automatic logic [W-1:0] ev(input int st, input int pw, input int ps,
      input int irw, input int rw, input int rd, input int ws, input int ex,
      input int asb, input int aop, input int mr, input int mw, input int dn,
      input int er);
    return {1'(pw), 2'(ps), 1'(irw), 1'(rw), 2'(rd), 2'(ws), 1'(ex), 1'(asb),
            3'(aop), 1'(mr), 1'(mw), 3'(st), 1'(dn), 1'(er)};
  endfunction

  function automatic bit legal(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'b000000)
      return fn == 6'b100001 || fn == 6'b100011 || fn == 6'b001000 || fn == 6'b000000;
    return op == 6'b001101 || op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000100 || op == 6'b001111 || op == 6'b000011;
  endfunction

  // Expected per-cycle outputs of one instruction, phase by phase.
  task automatic build(input int cls, input int z, input int w);
    int ex, asb, aop, rtype;
    exp_q.push_back(ev(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    ex    = (cls == C_ORI || cls == C_LUI) ? 1 : 0;
    asb   = (cls == C_ORI || cls == C_LUI || cls == C_LW || cls == C_SW) ? 1 : 0;
    rtype = (cls == C_ADDU || cls == C_SUBU || cls == C_NOP) ? 1 : 0;
    aop   = (cls == C_SUBU || cls == C_BEQ) ? 1 : (cls == C_ORI) ? 2 : (cls == C_LUI) ? 3 : 0;
    if (cls == C_ILL) begin
      exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      repeat (3) exp_q.push_back(ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
      return;
    end
    if (cls == C_JAL) begin
      exp_q.push_back(ev(1, 1, 2, 0, 1, 2, 2, 0, 0, 0, 0, 0, 1, 0));
      return;
    end
    if (cls == C_JR) begin
      exp_q.push_back(ev(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      return;
    end
    exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0, ex, 0, 0, 0, 0, 0, 0));
    if (cls == C_BEQ) begin
      exp_q.push_back(ev(2, z, 1, 0, 0, 0, 0, 0, 0, aop, 0, 0, 1, 0));
      return;
    end
    exp_q.push_back(ev(2, 0, 0, 0, 0, 0, 0, ex, asb, aop, 0, 0, 0, 0));
    if (cls == C_LW || cls == C_SW) begin
      for (int i = 0; i < w && i < MAXW; i++)
        exp_q.push_back(ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, cls == C_SW, 0, 0));
      if (w >= MAXW) begin
        repeat (3) exp_q.push_back(ev(5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
        return;
      end
      exp_q.push_back(ev(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, cls == C_SW, cls == C_SW, 0));
      if (cls == C_SW) return;
    end
    exp_q.push_back(ev(4, 0, 0, 0, 1, rtype, cls == C_LW, ex, 0, 0, 0, 0, 1, 0));
  endtask

  // scoreboard compare
  task automatic check(input string name, input int c, input logic [W-1:0] got,
                       input logic [W-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, c, got, want);
    end
  endtask

  task automatic pin(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL model_%s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Called just after a compare in the low clock phase; leaves DUT in FETCH.
  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 check("rst", 0, act, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // driver: picks the encoding, drives one instruction and compares each cycle
  task automatic run(input int cls, input int z, input int w, input int rst_at);
    bit is_mem;
    int n;
    case (cls)
      C_ADDU: begin cur_op = 6'b000000; cur_fn = 6'b100001; end
      C_SUBU: begin cur_op = 6'b000000; cur_fn = 6'b100011; end
      C_NOP:  begin cur_op = 6'b000000; cur_fn = 6'b000000; end
      C_JR:   begin cur_op = 6'b000000; cur_fn = 6'b001000; end
      C_ORI:  begin cur_op = 6'b001101; cur_fn = 6'($urandom); end
      C_LW:   begin cur_op = 6'b100011; cur_fn = 6'($urandom); end
      C_SW:   begin cur_op = 6'b101011; cur_fn = 6'($urandom); end
      C_BEQ:  begin cur_op = 6'b000100; cur_fn = 6'($urandom); end
      C_LUI:  begin cur_op = 6'b001111; cur_fn = 6'($urandom); end
      C_JAL:  begin cur_op = 6'b000011; cur_fn = 6'($urandom); end
      default: begin
        cur_op = 6'b111111; cur_fn = 6'($urandom);
        while (legal(cur_op, cur_fn)) begin
          cur_op = 6'($urandom); cur_fn = 6'($urandom);
        end
      end
    endcase
    is_mem = (cls == C_LW || cls == C_SW);
    exp_q.delete();
    build(cls, z, w);
    n = exp_q.size();
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      opcode = (c == 1) ? cur_op : 6'($urandom);
      funct  = (c == 1) ? cur_fn : 6'($urandom);
      zero   = (c == 2) ? 1'(z) : 1'($urandom);
      if (is_mem && c >= 3 && c < 3 + w) mem_ready = 1'b0;
      else if (is_mem && c == 3 + w)     mem_ready = 1'b1;
      else                               mem_ready = 1'($urandom);
      #1 check("cyc", c, act, exp_q.pop_front());
      if (c == rst_at) begin
        do_reset();
        exp_q.delete();
        return;
      end
    end
    if (cls == C_ILL || (is_mem && w >= MAXW)) do_reset();
  endtask

  function automatic int count_bit(input int pos);
    int k = 0;
    foreach (exp_q[i]) if (exp_q[i][pos]) k++;
    return k;
  endfunction

  // stimulus + final report
  initial begin
    // hand-computed schedule lengths and counts pin the model
    exp_q.delete(); build(C_ORI, 0, 0);  pin("ori_cpi", exp_q.size(), 4);
    exp_q.delete(); build(C_LW, 0, 3);   pin("lw_cpi", exp_q.size(), 8);
    pin("lw_memreq", count_bit(6), 4);
    exp_q.delete(); build(C_SW, 0, 2);   pin("sw_cpi", exp_q.size(), 6);
    exp_q.delete(); build(C_BEQ, 1, 0);  pin("beq_cpi", exp_q.size(), 3);
    exp_q.delete(); build(C_JAL, 0, 0);  pin("jal_cpi", exp_q.size(), 2);
    exp_q.delete(); build(C_SW, 0, 99);  pin("sw_to_memreq", count_bit(6), 8);
    pin("sw_to_regwr", count_bit(16), 0);
    exp_q.delete();

    repeat (2) @(negedge clk);
    #1 check("rst_init", 0, act, ev(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1 reset_n = 1'b1;

    run(C_ORI, 0, 0, 2);      // reset asserted during EXEC
    run(C_ORI, 0, 0, -1);
    run(C_LW, 0, 3, -1);
    run(C_SW, 0, 100, -1);    // memory never answers
    run(C_BEQ, 1, 0, -1);
    run(C_BEQ, 0, 0, -1);
    run(C_JAL, 0, 0, -1);
    run(C_JR, 0, 0, -1);
    run(C_ILL, 0, 0, -1);
    run(C_NOP, 0, 0, -1);
    run(C_SW, 0, 0, -1);
    run(C_LW, 0, MAXW - 1, -1);
    run(C_LUI, 0, 0, -1);
    run(C_SUBU, 0, 0, -1);

    for (int k = 0; k < 200; k++) begin
      int cls, w, ra;
      cls = $urandom_range(0, 10);
      w   = ($urandom_range(0, 7) == 0) ? $urandom_range(MAXW, MAXW + 3) : $urandom_range(0, 5);
      ra  = ($urandom_range(0, 14) == 0) ? $urandom_range(0, 2) : -1;
      run(cls, $urandom_range(0, 1), w, ra);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
